// File: rtl/tcdm_pkg.sv
// Shared TCDM request/response types and sizing helpers for the bank-side
// request arbiter.
package tcdm_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefNumInputs      = 8;
  localparam int unsigned DefMaxOutstanding = 8;
  localparam int unsigned IniAddrWidth      = idx_width(DefNumInputs);
  localparam int unsigned AddrWidth         = 32;
  localparam int unsigned DataWidth         = 32;
  localparam int unsigned BeWidth           = DataWidth / 8;
  localparam int unsigned AmoWidth          = 4;
  localparam int unsigned TagWidth          = 4;

  typedef logic [AddrWidth-1:0] local_req_interco_addr_t;

  typedef struct packed {
    logic [IniAddrWidth-1:0] ini_addr;
    logic [TagWidth-1:0]     tag;
  } bank_metadata_t;

  localparam int unsigned MetaWidth = $bits(bank_metadata_t);

  typedef struct packed {
    local_req_interco_addr_t addr;
    bank_metadata_t          meta;
    logic [AmoWidth-1:0]     amo;
    logic                    write;
    logic [DataWidth-1:0]    wdata;
    logic [BeWidth-1:0]      be;
  } tcdm_req_t;

  typedef struct packed {
    bank_metadata_t       meta;
    logic [DataWidth-1:0] rdata;
  } tcdm_resp_t;

endpackage

// File: rtl/tcdm_rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_i,
// wrapping at NumInputs.
module tcdm_rr_pick #(
  parameter int unsigned NumInputs = 8,
  parameter int unsigned IdxWidth  = 3
) (
  input  logic [NumInputs-1:0] valid_i,
  input  logic [IdxWidth-1:0]  rr_i,
  output logic [IdxWidth-1:0]  gnt_o,
  output logic                 any_o
);

  localparam int unsigned Iw = IdxWidth + 1;

  logic [IdxWidth:0] idx;

  always_comb begin
    gnt_o = rr_i;
    any_o = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      idx = {1'b0, rr_i} + Iw'(i);
      if (idx >= Iw'(NumInputs)) idx = idx - Iw'(NumInputs);
      if (!any_o && valid_i[idx[IdxWidth-1:0]]) begin
        any_o = 1'b1;
        gnt_o = idx[IdxWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_req_arbiter.sv
// Round-robin merge of initiator requests onto one TCDM adapter port with an
// outstanding-request cap and ini_addr-based response routing.
// Optional back-pressure statistics counter: define TCDM_ARB_STATS_EN.
module tcdm_bank_req_arbiter
  import tcdm_pkg::*;
#(
  parameter int unsigned NumInputs      = DefNumInputs,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumInputs-1:0]                     req_valid_i,
  output logic [NumInputs-1:0]                     req_ready_o,
  input  tcdm_req_t [NumInputs-1:0]                req_i,
  output logic                                     req_valid_o,
  input  logic                                     req_ready_i,
  output tcdm_req_t                                req_o,
  input  logic                                     resp_valid_i,
  output logic                                     resp_ready_o,
  input  tcdm_resp_t                               resp_i,
  output logic [NumInputs-1:0]                     resp_valid_o,
  input  logic [NumInputs-1:0]                     resp_ready_i,
  output tcdm_resp_t                               resp_o,
  output logic [idx_width(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic [31:0]                              stall_cnt_o
);

  localparam int unsigned CntWidth = idx_width(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0]     CntMax     = CntWidth'(MaxOutstanding);
  localparam logic [IniAddrWidth-1:0] LastIdx    = IniAddrWidth'(NumInputs - 1);
  localparam logic [IniAddrWidth:0]   NumInputsW = (IniAddrWidth + 1)'(NumInputs);

  logic [IniAddrWidth-1:0] rr_q, rr_d, gnt_q, gnt_d;
  logic [IniAddrWidth-1:0] pick_idx, grant, resp_idx;
  logic                    lock_q, lock_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    pick_any, full, req_hs, resp_hs, resp_idx_ok;

  tcdm_rr_pick #(
    .NumInputs (NumInputs),
    .IdxWidth  (IniAddrWidth)
  ) i_rr_pick (
    .valid_i (req_valid_i),
    .rr_i    (rr_q),
    .gnt_o   (pick_idx),
    .any_o   (pick_any)
  );

  // A locked grant must complete even when the counter is at its cap.
  always_comb begin
    full        = (cnt_q == CntMax);
    grant       = lock_q ? gnt_q : pick_idx;
    req_valid_o = !rst_i && (lock_q || (pick_any && !full));
    req_o       = req_i[grant];
    req_o.meta.ini_addr = grant;
    req_ready_o = '0;
    req_ready_o[grant] = req_valid_o & req_ready_i;
    req_hs      = req_valid_o & req_ready_i;

    resp_idx     = resp_i.meta.ini_addr;
    resp_idx_ok  = ({1'b0, resp_idx} < NumInputsW);
    resp_valid_o = '0;
    resp_ready_o = 1'b0;
    if (!rst_i) begin
      if (resp_idx_ok) begin
        resp_valid_o[resp_idx] = resp_valid_i;
        resp_ready_o           = resp_ready_i[resp_idx];
      end else begin
        resp_ready_o = 1'b1;
      end
    end
    resp_hs = resp_valid_i & resp_ready_o;
  end

  assign resp_o        = resp_i;
  assign outstanding_o = cnt_q;

  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    gnt_d  = gnt_q;
    if (req_valid_o && !req_ready_i) begin
      lock_d = 1'b1;
      gnt_d  = grant;
    end
    if (req_hs) begin
      lock_d = 1'b0;
      rr_d   = (grant == LastIdx) ? '0 : grant + 1'b1;
    end
    cnt_d = cnt_q;
    case ({req_hs, resp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      gnt_q  <= '0;
      cnt_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      gnt_q  <= gnt_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef TCDM_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_inc;

  always_comb begin
    stall_inc = (req_valid_o && !req_ready_i) || (|req_valid_i && full);
    stall_d   = stall_q;
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  for (genvar i = 0; i < NumInputs; i++) begin : g_req_stable
    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      req_valid_i[i] && !req_ready_o[i] |=> req_valid_i[i] && $stable(req_i[i]));
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(resp_hs && (cnt_q == '0)));

  a_resp_idx_ok: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_valid_i |-> resp_idx_ok);

endmodule
